// File: rtl/int_requantize_pkg.sv
// Shared helpers for integer requantization: saturation bounds and the
// shift/clamp step applied to a pre-rounded stage-1 sum.
package int_requantize_pkg;

    // Result of one lane's shift-and-clamp, plus whether it clamped.
    typedef struct packed {
        logic               clamped;
        logic signed [63:0] value;
    } requant_t;

    // Largest representable signed value of the given width.
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    // Smallest representable signed value of the given width.
    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    // The rounding offset is already folded into sum, so a floor shift
    // yields round-half-toward-plus-infinity before the clamp.
    function automatic requant_t requant(input logic signed [63:0] sum,
                                         input int shift,
                                         input int out_width);
        logic signed [63:0] shifted;
        requant_t           res;
        shifted     = sum >>> shift;
        res.clamped = 1'b1;
        res.value   = shifted;
        if (shifted > sat_max(out_width)) begin
            res.value = sat_max(out_width);
        end else if (shifted < sat_min(out_width)) begin
            res.value = sat_min(out_width);
        end else begin
            res.clamped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/int_requantize.sv
// Two-stage requantizer: stage 1 adds bias and the rounding offset at full
// precision, stage 2 shifts and saturates each lane to OUT_WIDTH and counts
// clamped lanes.
//
// Handshake: a beat moves on valid && ready. valid never drops and data never
// changes while valid is high and ready is low. Each stage loads whenever it
// is empty or its current beat leaves in the same cycle. Stage sums are kept
// in 64-bit arithmetic, so IN_WIDTH is limited to 62.
module int_requantize
    import int_requantize_pkg::*;
#(
    parameter int NUM       = 1,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM*IN_WIDTH-1:0]   in,
    input  logic [NUM*IN_WIDTH-1:0]   bias,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM*OUT_WIDTH-1:0]  out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_WIDTH-1:0]      sat_count,
    input  logic                      sat_clear
);

    localparam int S1_W = IN_WIDTH + 2;
    localparam logic [S1_W-1:0] ROUND = {{(S1_W-1){1'b0}}, 1'b1} << (SHIFT - 1);

    logic                         s1_valid;
    logic [NUM-1:0][S1_W-1:0]     s1_data;
    logic [NUM-1:0][S1_W-1:0]     s1_next;
    logic                         s2_valid;
    logic [NUM*OUT_WIDTH-1:0]     s2_data;
    logic [NUM*OUT_WIDTH-1:0]     q_next;
    logic                         s2_load;
    logic [NUM-1:0]               lane_sat;
    logic [CNT_WIDTH:0]           sat_add;
    logic [CNT_WIDTH:0]           sat_sum;
    logic [CNT_WIDTH-1:0]         cnt_next;
    requant_t                     rq [NUM];
    logic                         rq_unused;

    // Flow control: stage 2 drains on out_ready, stage 1 drains into stage 2.
    always_comb begin
        s2_load   = s1_valid && (!s2_valid || out_ready);
        in_ready  = !rst && (!s1_valid || s2_load);
        out_valid = s2_valid;
        out       = s2_data;
    end

    // Stage-1 datapath: sign-extend, add bias and rounding offset without overflow.
    always_comb begin
        s1_next = '0;
        for (int i = 0; i < NUM; i++) begin
            s1_next[i] = {{2{in[i*IN_WIDTH+IN_WIDTH-1]}}, in[i*IN_WIDTH +: IN_WIDTH]}
                       + {{2{bias[i*IN_WIDTH+IN_WIDTH-1]}}, bias[i*IN_WIDTH +: IN_WIDTH]}
                       + ROUND;
        end
    end

    // Stage-2 datapath: shift, clamp and flag saturated lanes; tally them.
    always_comb begin
        q_next    = '0;
        lane_sat  = '0;
        sat_add   = '0;
        rq_unused = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            rq[i] = requant({{(64-S1_W){s1_data[i][S1_W-1]}}, s1_data[i]},
                            SHIFT, OUT_WIDTH);
            q_next[i*OUT_WIDTH +: OUT_WIDTH] = rq[i].value[OUT_WIDTH-1:0];
            lane_sat[i] = rq[i].clamped;
            sat_add     = sat_add + {{CNT_WIDTH{1'b0}}, lane_sat[i]};
            rq_unused   = rq_unused ^ (^rq[i].value[63:OUT_WIDTH]);
        end
    end

    // Next saturation count: optional clear, then add, pinned at all-ones.
    always_comb begin
        sat_sum  = (sat_clear ? {(CNT_WIDTH+1){1'b0}} : {1'b0, sat_count}) + sat_add;
        cnt_next = sat_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sat_sum[CNT_WIDTH-1:0];
    end

    // Stage-1 register: valid bit reset, data loaded on input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
        if (in_valid && in_ready) begin
            s1_data <= s1_next;
        end
    end

    // Stage-2 register: holds its beat while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (!s2_valid || out_ready) begin
            s2_valid <= s1_valid;
        end
        if (s2_load) begin
            s2_data <= q_next;
        end
    end

    // Saturation counter: advances only on stage-2 loads, clear otherwise zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (s2_load) begin
            sat_count <= cnt_next;
        end else if (sat_clear) begin
            sat_count <= '0;
        end
    end

endmodule

// File: tb/tb_int_requantize.sv
// Bench for int_requantize with NUM=2, IN_WIDTH=16, OUT_WIDTH=8, SHIFT=4.
module tb_int_requantize;

    localparam int NUM = 2;
    localparam int IW  = 16;
    localparam int OW  = 8;
    localparam int SH  = 4;
    localparam int CW  = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NUM*IW-1:0] in_bus;
    logic [NUM*IW-1:0] bias_bus;
    logic              in_valid;
    logic              in_ready;
    logic [NUM*OW-1:0] out;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     sat_count;
    logic              sat_clear;

    int checks   = 0;
    int failures = 0;

    logic [NUM*OW-1:0] exp_q[$];
    int                model_cnt = 0;
    logic              stall_prev = 1'b0;
    logic [NUM*OW-1:0] held;

    int_requantize #(
        .NUM(NUM), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in(in_bus), .bias(bias_bus),
        .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .sat_count(sat_count), .sat_clear(sat_clear)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: real-valued floor((a+b)/16 + 1/2), then clamp to int8.
    function automatic int model_lane(input int a, input int b, output bit sat);
        longint s;
        longint q;
        s   = longint'(a) + longint'(b) + 8;
        q   = (s >= 0) ? s / 16 : -((-s + 15) / 16);
        sat = 1'b0;
        if (q > 127) begin q = 127; sat = 1'b1; end
        else if (q < -128) begin q = -128; sat = 1'b1; end
        return int'(q);
    endfunction

    function automatic logic [NUM*OW-1:0] model_beat(input logic [NUM*IW-1:0] i,
                                                     input logic [NUM*IW-1:0] b,
                                                     output int nsat);
        logic [NUM*OW-1:0] r;
        bit s;
        int q;
        r    = '0;
        nsat = 0;
        for (int k = 0; k < NUM; k++) begin
            q = model_lane(int'($signed(i[k*IW +: IW])), int'($signed(b[k*IW +: IW])), s);
            r[k*OW +: OW] = 8'(q);
            nsat += int'(s);
        end
        return r;
    endfunction

    // scoreboard / compare process, sampled on the falling edge
    always @(negedge clk) begin
        int ns;
        if (rst) begin
            exp_q.delete();
            model_cnt  = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", longint'(out_valid), 1);
                check("hold_data", longint'(out), longint'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_extra actual=%h required=no_beat", out);
                end else begin
                    check("out_data", longint'(out), longint'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_beat(in_bus, bias_bus, ns));
                model_cnt = (model_cnt + ns > 65535) ? 65535 : model_cnt + ns;
            end
            stall_prev = out_valid && !out_ready;
            held       = out;
        end
    end

    // driver tasks (all start and end one time unit after a rising edge)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int a0, input int a1, input int b0, input int b1);
        bit ok;
        ok       = 1'b0;
        in_bus   = {16'(a1), 16'(a0)};
        bias_bus = {16'(b1), 16'(b0)};
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic lit_beat(input string name, input int a0, input int a1,
                            input int b0, input int b1, input int e0, input int e1);
        logic [NUM*OW-1:0] e;
        e = {8'(e1), 8'(e0)};
        send_beat(a0, a1, b0, b1);
        @(negedge clk);
        check({name, "_lat1"}, longint'(out_valid), 0);
        @(negedge clk);
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_data"}, longint'(out), longint'(e));
        tick();
    endtask

    task automatic check_cnt(input string name, input int lit);
        repeat (3) tick();
        @(negedge clk);
        check({name, "_lit"}, longint'(sat_count), lit);
        check({name, "_model"}, longint'(sat_count), model_cnt);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int acc;
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
        in_bus = '0; bias_bus = '0;
        tick();
        @(negedge clk);
        check("in_ready_in_rst", longint'(in_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_sat_count", longint'(sat_count), 0);
        tick();

        // rounding, saturation, bias
        lit_beat("round24", 24, -24, 0, 0, 2, -1);
        lit_beat("round8", 8, -8, 0, 0, 1, 0);
        lit_beat("round_neg", -9, 23, 0, 0, -1, 1);
        lit_beat("round_low", -8, 7, 0, 0, 0, 0);
        lit_beat("sat", 32767, -32768, 16, -16, 127, -128);
        check_cnt("sat_cnt", 2);
        lit_beat("bias", 100, 0, -200, 40, -6, 3);
        check_cnt("bias_cnt", 2);

        // backpressure with an incrementing stream
        out_ready = 1'b0;
        v = 3;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_bus    = {16'(-(v * 16)), 16'(v * 16)};
            bias_bus  = '0;
            in_valid  = (v < 15);
            out_ready = (c >= 5);
            @(negedge clk);
            if (c == 4) begin
                check("bp_accepted", acc, 2);
                check("bp_in_ready", longint'(in_ready), 0);
                check("bp_out_first", longint'(out), longint'({8'(-3), 8'(3)}));
            end
            if (c >= 5 && c <= 16) check("bp_no_gap", longint'(out_valid), 1);
            if (in_valid && in_ready) begin
                v++;
                acc++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_total", acc, 12);
        check_cnt("bp_cnt", 2);

        // counter: clear, preload, saturate, clear with coincident load
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        model_cnt = 0;
        check_cnt("clear_only", 0);
        in_bus   = {16'(-32768), 16'(32767)};
        bias_bus = '0;
        in_valid = 1'b1;
        n = 0;
        for (int k = 0; k < 40000 && n < 32767; k++) begin
            @(negedge clk);
            if (in_ready) n++;
            tick();
        end
        in_valid = 1'b0;
        check("preload_beats", n, 32767);
        check_cnt("preload", 65534);
        send_beat(32767, -32768, 0, 0);
        check_cnt("cnt_top", 65535);
        send_beat(32767, -32768, 0, 0);
        check_cnt("cnt_nowrap", 65535);
        send_beat(32767, 0, 0, 0);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        model_cnt = 1;
        check_cnt("clear_load", 1);

        // reset with two beats in flight
        out_ready = 1'b0;
        send_beat(32767, -32768, 0, 0);
        send_beat(32767, -32768, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", longint'(in_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", longint'(out_valid), 0);
        check("post_rst_in_ready", longint'(in_ready), 1);
        check("post_rst_cnt", longint'(sat_count), 0);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_quiet", longint'(out_valid), 0);
            tick();
        end
        lit_beat("after_rst", 24, -24, 0, 0, 2, -1);
        check_cnt("after_rst_cnt", 0);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
